// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: instruction field positions,
// the NOP encoding, the register-zero index and the IF/ID per-cycle mode.
package mips_pkg;

  // All-zero word (sll $0,$0,0) used as the pipeline NOP
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Source register field positions in an instruction word
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  // $zero can never carry a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // What the IF/ID boundary does in a given cycle (decoded, never stored)
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_FLUSH = 2'd1,
    MODE_STALL = 2'd2,
    MODE_LOAD  = 2'd3
  } if_id_mode_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Purely combinational: looks at the instruction
// sitting in IF/ID and the load (if any) sitting in ID/EX. rt is compared for
// every opcode, so an I-type whose rt is really a destination can stall
// needlessly; that cost is accepted to keep the compare trivial.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  output logic        hazard
);

  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       match_s;
  logic       unused_bits_s;

  assign rs_s    = instr[RS_HI:RS_LO];
  assign rt_s    = instr[RT_HI:RT_LO];
  assign match_s = (idex_rt == rs_s) || (idex_rt == rt_s);

  // Opcode, rd, shamt and funct play no part in the dependency check
  assign unused_bits_s = ^{instr[31:26], instr[15:0]};

  assign hazard = valid && idex_mem_read && (idex_rt != REG_ZERO) && match_s;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline boundary: holds the fetched instruction and its PC+4,
// resolves freeze / squash / load-use stall / normal advance each cycle, and
// keeps saturating debug counters of stall cycles and flushes.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int PC_WIDTH  = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  PCnext_in,
  input  logic [31:0]          Instruction_in,
  input  logic                 ext_stall,
  input  logic                 branch_taken,
  input  logic                 idex_mem_read,
  input  logic [4:0]           idex_rt,
  output logic [PC_WIDTH-1:0]  PCnext_out,
  output logic [31:0]          Instruction_out,
  output logic                 valid_out,
  output logic                 pc_write,
  output logic                 bubble,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  logic [PC_WIDTH-1:0]  pc_r;
  logic [31:0]          instr_r;
  logic                 valid_r;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;
  logic                 hazard_s;
  if_id_mode_e          mode_s;

  // The hazard is judged on what is already registered, never on Instruction_in
  hazard_detect u_hazard_detect (
    .instr         (instr_r),
    .valid         (valid_r),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .hazard        (hazard_s)
  );

  // Priority decode: freeze beats squash beats load-use stall beats advance
  always_comb begin
    mode_s = MODE_LOAD;
    if (ext_stall) begin
      mode_s = MODE_HOLD;
    end else if (branch_taken) begin
      mode_s = MODE_FLUSH;
    end else if (hazard_s) begin
      mode_s = MODE_STALL;
    end else begin
      mode_s = MODE_LOAD;
    end
  end

  // PC enable and ID/EX bubble request follow directly from the mode
  always_comb begin
    pc_write = 1'b0;
    bubble   = 1'b0;
    case (mode_s)
      MODE_HOLD: begin
        pc_write = 1'b0;
        bubble   = 1'b0;
      end
      MODE_FLUSH: begin
        pc_write = 1'b1;
        bubble   = 1'b0;
      end
      MODE_STALL: begin
        pc_write = 1'b0;
        bubble   = 1'b1;
      end
      MODE_LOAD: begin
        pc_write = 1'b1;
        bubble   = 1'b0;
      end
      default: begin
        pc_write = 1'b0;
        bubble   = 1'b0;
      end
    endcase
  end

  // Pipeline register: replaced by NOP on a squash, refilled on advance, else held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= '0;
      instr_r <= NOP;
      valid_r <= 1'b0;
    end else begin
      case (mode_s)
        MODE_FLUSH: begin
          pc_r    <= '0;
          instr_r <= NOP;
          valid_r <= 1'b0;
        end
        MODE_LOAD: begin
          pc_r    <= PCnext_in;
          instr_r <= Instruction_in;
          valid_r <= 1'b1;
        end
        default: begin
          pc_r    <= pc_r;
          instr_r <= instr_r;
          valid_r <= valid_r;
        end
      endcase
    end
  end

  // Debug event counters; a squashed hazard is not a stall and is not counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      case (mode_s)
        MODE_STALL: stall_cnt_r <= sat_inc(stall_cnt_r);
        MODE_FLUSH: flush_cnt_r <= sat_inc(flush_cnt_r);
        default: begin
          stall_cnt_r <= stall_cnt_r;
          flush_cnt_r <= flush_cnt_r;
        end
      endcase
    end
  end

  assign PCnext_out      = pc_r;
  assign Instruction_out = instr_r;
  assign valid_out       = valid_r;
  assign stall_cnt       = stall_cnt_r;
  assign flush_cnt       = flush_cnt_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: a behavioural model of the boundary is
// advanced on every rising edge and compared against the DUT on every falling
// edge; directed scenarios add literal expectations that pin the model.
module tb_if_id_stage;

  localparam int PW   = 6;
  localparam int CW   = 16;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] PCnext_in;
  logic [31:0]   Instruction_in;
  logic          ext_stall;
  logic          branch_taken;
  logic          idex_mem_read;
  logic [4:0]    idex_rt;
  logic [PW-1:0] PCnext_out;
  logic [31:0]   Instruction_out;
  logic          valid_out;
  logic          pc_write;
  logic          bubble;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  if_id_stage #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .PCnext_in       (PCnext_in),
    .Instruction_in  (Instruction_in),
    .ext_stall       (ext_stall),
    .branch_taken    (branch_taken),
    .idex_mem_read   (idex_mem_read),
    .idex_rt         (idex_rt),
    .PCnext_out      (PCnext_out),
    .Instruction_out (Instruction_out),
    .valid_out       (valid_out),
    .pc_write        (pc_write),
    .bubble          (bubble),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model of what IF/ID holds
  logic [PW-1:0] m_pc;
  logic [31:0]   m_instr;
  logic          m_valid;
  int            m_stall;
  int            m_flush;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A load in ID/EX feeding rs or rt of the held instruction, ignoring $zero
  function automatic bit model_hazard();
    logic [4:0] rs;
    logic [4:0] rt;
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    return m_valid && idex_mem_read && (idex_rt != 5'd0) && (idex_rt == rs || idex_rt == rt);
  endfunction

  task automatic model_reset();
    m_pc    = '0;
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One rising edge: advance the model with the inputs the DUT sees, then step off the edge
  task automatic tick();
    bit hz;
    @(posedge clk);
    hz = model_hazard();
    if (rst) begin
      model_reset();
    end else if (ext_stall) begin
      // frozen
    end else if (branch_taken) begin
      m_pc = '0; m_instr = 32'h0; m_valid = 1'b0;
      if (m_flush < CMAX) m_flush++;
    end else if (hz) begin
      if (m_stall < CMAX) m_stall++;
    end else begin
      m_pc = PCnext_in; m_instr = Instruction_in; m_valid = 1'b1;
    end
    #1;
  endtask

  // Compare every DUT output against the model once per cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      bit hz;
      hz = model_hazard();
      check("PCnext_out", 32'(PCnext_out), 32'(m_pc));
      check("Instruction_out", Instruction_out, m_instr);
      check("valid_out", 32'(valid_out), 32'(m_valid));
      check("pc_write", 32'(pc_write), 32'(!ext_stall && (branch_taken || !hz)));
      check("bubble", 32'(bubble), 32'(!ext_stall && !branch_taken && hz));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  end

  task automatic set_in(input logic es, input logic bt, input logic mr, input logic [4:0] rt,
                        input logic [PW-1:0] pc, input logic [31:0] ins);
    ext_stall = es; branch_taken = bt; idex_mem_read = mr; idex_rt = rt;
    PCnext_in = pc; Instruction_in = ins;
  endtask

  initial begin
    logic [31:0] r_ins;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 32'h0);
    model_reset();
    #2 rst = 1'b1;
    #1 cmp_en = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_instr", Instruction_out, 32'h0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd1);
    rst = 1'b0;

    // Normal flow: one-cycle latency
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd4, 32'h8C22_0004);
    tick();
    check("load_instr", Instruction_out, 32'h8C22_0004);
    check("load_pc", 32'(PCnext_out), 32'd4);
    check("load_valid", 32'(valid_out), 32'd1);

    // Load-use: add $3,$2,$1 behind lw into $2
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd8, 32'h0041_1820);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 5'd2, 6'd12, 32'h1111_1111);
    #1;
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_bubble", 32'(bubble), 32'd1);
    tick();
    check("lu_held", Instruction_out, 32'h0041_1820);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 5'd2, 6'd12, 32'h1111_1111);
    tick();
    check("lu_resume", Instruction_out, 32'h1111_1111);

    // $zero never stalls
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd16, 32'h0005_0000);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 5'd0, 6'd20, 32'h2222_2222);
    #1;
    check("zero_pc_write", 32'(pc_write), 32'd1);
    check("zero_bubble", 32'(bubble), 32'd0);

    // Flush beats a simultaneous hazard (held instr has rt=5)
    set_in(1'b0, 1'b1, 1'b1, 5'd5, 6'd20, 32'h2222_2222);
    #1;
    check("fl_pc_write", 32'(pc_write), 32'd1);
    check("fl_bubble", 32'(bubble), 32'd0);
    tick();
    check("fl_instr", Instruction_out, 32'h0);
    check("fl_valid", 32'(valid_out), 32'd0);
    check("fl_flush_cnt", 32'(flush_cnt), 32'd1);
    check("fl_stall_cnt", 32'(stall_cnt), 32'd1);

    // Freeze beats a pending branch for 3 cycles, then the flush executes
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd24, 32'h3333_3333);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 5'd0, 6'd28, 32'h4444_4444);
    repeat (3) tick();
    check("es_frozen", Instruction_out, 32'h3333_3333);
    check("es_pc_write", 32'(pc_write), 32'd0);
    check("es_flush_cnt", 32'(flush_cnt), 32'd1);
    ext_stall = 1'b0;
    tick();
    check("es_release_instr", Instruction_out, 32'h0);
    check("es_release_flush", 32'(flush_cnt), 32'd2);

    // Randomized traffic with register fields drawn from a small pool so hazards occur
    for (int i = 0; i < 600; i++) begin
      r_ins = $urandom;
      r_ins[25:21] = 5'($urandom_range(0, 3));
      r_ins[20:16] = 5'($urandom_range(0, 3));
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
             6'($urandom), r_ins);
      tick();
    end

    // Saturation: a load that never leaves ID/EX stalls every cycle
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd32, 32'h0041_1820);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 5'd1, 6'd36, 32'h5555_5555);
    repeat (65540) tick();
    check("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_held", Instruction_out, 32'h0041_1820);

    // Asynchronous reset between edges
    rst = 1'b1;
    model_reset();
    #2;
    check("arst_instr", Instruction_out, 32'h0);
    check("arst_pc", 32'(PCnext_out), 32'd0);
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 6'd40, 32'h6666_6666);
    tick();
    check("post_rst_load", Instruction_out, 32'h6666_6666);
    check("post_rst_valid", 32'(valid_out), 32'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Pipeline boundary between instruction fetch and decode in the 5-stage MIPS core. Registers the fetched instruction and its PC+4 value. Contains the load-use hazard detector that freezes the PC and this register and inserts a bubble into ID/EX. Also squashes the fetched instruction on a taken branch/jump and keeps saturating stall/flush event counters for debug.

## Interface
Parameters:
- PC_WIDTH, 6, width of PC values; must match the fetch stage.
- CNT_WIDTH, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCnext_in  in  PC_WIDTH  PC+4 from fetch.
- Instruction_in  in  32  instruction word from fetch.
- ext_stall  in  1  global freeze request (e.g. data memory busy).
- branch_taken  in  1  taken branch/jump resolved downstream; squash fetched instruction.
- idex_mem_read  in  1  instruction currently in ID/EX is a load.
- idex_rt  in  5  destination register of that load.
- PCnext_out  out  PC_WIDTH  registered PC+4.
- Instruction_out  out  32  registered instruction (NOP when invalid).
- valid_out  out  1  registered instruction is real.
- pc_write  out  1  fetch PC may advance this cycle.
- bubble  out  1  ID/EX must load control-zero (NOP) this cycle.
- stall_cnt  out  CNT_WIDTH  load-use stall cycles since reset.
- flush_cnt  out  CNT_WIDTH  flushes since reset.

## Operation
- Hazard, combinational: hazard = valid_out & idex_mem_read & (idex_rt != 0) & ((idex_rt == Instruction_out[25:21]) | (idex_rt == Instruction_out[20:16])).
- rt is compared for every opcode; a false stall on I-type is accepted.
- Per-cycle action, priority high to low:
  1. ext_stall=1:
     - HOLD: register unchanged; pc_write=0; bubble=0; counters unchanged.
     - branch_taken is ignored while frozen. Upstream holds it, and it is acted on the first cycle ext_stall=0.
  2. branch_taken=1 (FLUSH):
     - Register loads NOP (32'h0000_0000), PCnext_out=0, valid_out=0.
     - pc_write=1 so fetch takes the target; bubble=0; flush_cnt+1.
     - Flush overrides a simultaneous hazard, and that hazard is not counted.
  3. hazard=1 (STALL): register unchanged; pc_write=0; bubble=1; stall_cnt+1.
  4. otherwise (LOAD): register loads PCnext_in and Instruction_in; valid_out=1; pc_write=1; bubble=0.
- The mode (HOLD/FLUSH/STALL/LOAD) is a combinational decode, not stored state. Exactly one mode per cycle.
- Counters saturate at all-ones and never wrap.
- Reset values: PCnext_out=0, Instruction_out=0, valid_out=0, stall_cnt=0, flush_cnt=0.
- pc_write and bubble are combinational. During reset they are 1 and 0 respectively, because valid_out=0 means no hazard.

## Timing
- Latency: fetch outputs in cycle N appear on the outputs after edge N+1 (one cycle).
- Load-use costs exactly one stall cycle:
  - After the STALL edge, ID/EX holds the bubble, so idex_mem_read=0 and the hazard clears.
  - The held instruction proceeds next cycle.
- Flush: the instruction present at the flush edge is replaced by NOP. The instruction fetched from the target arrives one cycle later.
- rst asserted mid-stall or mid-flush clears everything immediately, without waiting for a clock. The first edge after deassertion performs LOAD (absent other inputs).
- hazard, pc_write and bubble must settle within the same cycle from registered outputs and idex_* inputs. There is no path from Instruction_in to them.

## Structure
- Shared package (mips_pkg) holds:
  - the NOP constant;
  - RS/RT field bit positions (25:21, 20:16);
  - register-zero index.
- Sub-module hazard_detect: purely combinational. Inputs are the registered instruction, valid_out, idex_mem_read and idex_rt; output is hazard.
- Top-level if_id_stage holds:
  - the priority mux;
  - the pipeline register;
  - the two saturating counters.

## Test plan
- Reset then normal flow:
  - Stimulus: rst pulse, then feed 32'h8C22_0004 / PCnext 6'd4.
  - During reset, outputs are 0, valid_out=0 and pc_write=1.
  - One edge later, Instruction_out=32'h8C22_0004, PCnext_out=4, valid_out=1.
- Load-use:
  - Stimulus: IF/ID holds add $3,$2,$1 (32'h0041_1820); idex_mem_read=1, idex_rt=2.
  - Required: pc_write=0, bubble=1, register unchanged and stall_cnt=1 after the edge.
  - With idex_mem_read=0 next cycle, LOAD resumes.
- No false hazard on $zero: idex_rt=0 with matching rs=0 -> hazard=0, pc_write=1.
- Flush vs hazard:
  - Stimulus: hazard condition and branch_taken=1 together.
  - Required: Instruction_out=0, valid_out=0, pc_write=1, bubble=0, flush_cnt=1, stall_cnt=0.
- ext_stall priority:
  - Stimulus: ext_stall=1 with branch_taken=1 for 3 cycles.
  - Required: register frozen, pc_write=0, counters unchanged.
  - On release, the flush executes.
- Saturation and async reset:
  - Stimulus: force stall_cnt to all-ones, then one more stall.
  - Required: stall_cnt stays 16'hFFFF.
  - Assert rst between edges: all registered outputs go to 0 before the next edge.
